ibexc_tsmap_arbiter: RTL

IBEXC_TSMAP_ARBITER -- requirements
Module: ibexc_tsmap_arbiter

---
 rtl/ibexc_tsmap_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ibexc_tsmap_arbiter.sv
// TS map SRAM arbiter: the core has absolute read priority, and the revoker gets leftover cycles.
// Optional event counters are built only when IBEXC_TSMAP_ARB_STATS_EN is defined.
module ibexc_tsmap_arbiter #(
  parameter int unsigned TSMapSize   = 1024,
  parameter int unsigned StarveLimit = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_cs_i,
  input  logic [15:0] core_addr_i,
  output logic [31:0] core_rdata_o,
  input  logic        rev_req_i,
  input  logic        rev_we_i,
  input  logic [15:0] rev_addr_i,
  input  logic [31:0] rev_wdata_i,
  output logic        rev_gnt_o,
  output logic        rev_rvalid_o,
  output logic [31:0] rev_rdata_o,
  output logic        rev_err_o,
  output logic        rev_starve_o,
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] stat_core_o,
  output logic [31:0] stat_rev_o,
  output logic [31:0] stat_conflict_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StCoreRd = 3'd1;
  localparam logic [2:0] StRevRd  = 3'd2;
  localparam logic [2:0] StRevWr  = 3'd3;
  localparam logic [2:0] StRevErr = 3'd4;

  localparam logic [16:0] MapLimit = 17'(TSMapSize);
  localparam logic [7:0]  Limit    = 8'(StarveLimit);

  logic [2:0]  state_q, state_d;
  logic        core_oor_q;
  logic [31:0] core_hold_q;
  logic [7:0]  starve_cnt_q;

  logic        core_oor, rev_oor, core_go, rev_gnt;
  logic [31:0] core_rd_now;

  assign core_oor = {1'b0, core_addr_i} >= MapLimit;
  assign rev_oor  = {1'b0, rev_addr_i} >= MapLimit;
  assign core_go  = ~rst_i & core_cs_i;
  assign rev_gnt  = ~rst_i & rev_req_i & ~core_cs_i;

  assign rev_gnt_o = rev_gnt;

  always_comb begin
    mem_cs_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = core_addr_i;
    mem_wdata_o = rev_wdata_i;
    if (core_go) begin
      mem_cs_o = ~core_oor;
    end else if (rev_gnt) begin
      mem_cs_o   = ~rev_oor;
      mem_we_o   = rev_we_i & ~rev_oor;
      mem_addr_o = rev_addr_i;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (core_go) begin
      state_d = StCoreRd;
    end else if (rev_gnt) begin
      if (rev_oor) begin
        state_d = StRevErr;
      end else if (rev_we_i) begin
        state_d = StRevWr;
      end else begin
        state_d = StRevRd;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      core_oor_q   <= 1'b0;
      core_hold_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      core_oor_q <= core_oor;
      if (state_q == StCoreRd) begin
        core_hold_q <= core_rd_now;
      end
      if (rev_req_i && !rev_gnt) begin
        if (starve_cnt_q != Limit) begin
          starve_cnt_q <= starve_cnt_q + 8'd1;
        end
      end else begin
        starve_cnt_q <= '0;
      end
    end
  end

  // Outputs are masked during reset so the reset cycle itself shows reset values.
  assign core_rd_now  = core_oor_q ? 32'd0 : mem_rdata_i;
  assign core_rdata_o = rst_i ? 32'd0 : ((state_q == StCoreRd) ? core_rd_now : core_hold_q);

  always_comb begin
    rev_rvalid_o = 1'b0;
    rev_err_o    = 1'b0;
    rev_rdata_o  = '0;
    if (!rst_i) begin
      case (state_q)
        StRevRd: begin
          rev_rvalid_o = 1'b1;
          rev_rdata_o  = mem_rdata_i;
        end
        StRevWr:  rev_rvalid_o = 1'b1;
        StRevErr: begin
          rev_rvalid_o = 1'b1;
          rev_err_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rev_starve_o = ~rst_i & (starve_cnt_q == Limit);

`ifdef IBEXC_TSMAP_ARB_STATS_EN
  logic [31:0] stat_core_q, stat_rev_q, stat_conflict_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_core_q     <= '0;
      stat_rev_q      <= '0;
      stat_conflict_q <= '0;
    end else begin
      if (core_go && !core_oor && stat_core_q != 32'hFFFF_FFFF) begin
        stat_core_q <= stat_core_q + 32'd1;
      end
      if (rev_gnt && stat_rev_q != 32'hFFFF_FFFF) begin
        stat_rev_q <= stat_rev_q + 32'd1;
      end
      if (core_cs_i && rev_req_i && stat_conflict_q != 32'hFFFF_FFFF) begin
        stat_conflict_q <= stat_conflict_q + 32'd1;
      end
    end
  end

  assign stat_core_o     = rst_i ? 32'd0 : stat_core_q;
  assign stat_rev_o      = rst_i ? 32'd0 : stat_rev_q;
  assign stat_conflict_o = rst_i ? 32'd0 : stat_conflict_q;
`else
  assign stat_core_o     = '0;
  assign stat_rev_o      = '0;
  assign stat_conflict_o = '0;
`endif

endmodule
